// File: rtl/bht_update_ctrl.sv
// rtl/bht_update_ctrl.sv - branch history table update queue, read-port arbiter and updater FSM
module bht_update_ctrl #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bu0_valid,
  input  logic [63:0] bu0_pc,
  input  logic        bu0_taken,
  output logic        bu0_ready,
  input  logic        bu1_valid,
  input  logic [63:0] bu1_pc,
  input  logic        bu1_taken,
  output logic        bu1_ready,
  input  logic        fe_rd_req,
  input  logic [11:0] fe_rd_addr,
  output logic        fe_rd_grant,
  output logic        ram_rd_en,
  output logic [11:0] ram_rd_addr,
  input  logic [52:0] ram_rd_data,
  output logic        ram_wr_en,
  output logic [11:0] ram_wr_addr,
  output logic [52:0] ram_wr_data,
  output logic        init_done,
  output logic        busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [STV_W-1:0] STV_MAX   = STV_W'(STARVE_LIMIT);
  localparam logic [52:0]      INIT_WORD = {1'b0, 50'd0, 2'b01};

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_WT, S_WR} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [11:0]      sweep_addr;
  logic [11:0]      q_idx   [FIFO_DEPTH];
  logic [49:0]      q_tag   [FIFO_DEPTH];
  logic             q_taken [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             rr_ptr;
  logic [STV_W-1:0] starve_cnt;
  logic [52:0]      rd_q;

  logic             can_push;
  logic             push;
  logic             push_sel;
  logic             pop;
  logic             upd_forced;
  logic             upd_wins;
  logic [11:0]      head_idx;
  logic [49:0]      head_tag;
  logic             head_taken;
  logic             hit;
  logic [1:0]       cur_st;
  logic [1:0]       new_st;
  logic             unused_pc_lsbs;

  // Byte-offset bits of the PC never reach the table.
  assign unused_pc_lsbs = ^{bu0_pc[1:0], bu1_pc[1:0]};

  // Push side: ready reflects the registered count only, and a contested cycle goes to the rr port.
  assign init_done = (state != S_INIT);
  assign can_push  = init_done && (count != FULL_CNT);
  assign bu0_ready = can_push && !(bu0_valid && bu1_valid && rr_ptr);
  assign bu1_ready = can_push && !(bu0_valid && bu1_valid && !rr_ptr);
  assign push      = (bu0_valid && bu0_ready) || (bu1_valid && bu1_ready);
  assign push_sel  = !(bu0_valid && bu0_ready);

  assign head_idx   = q_idx[rd_ptr];
  assign head_tag   = q_tag[rd_ptr];
  assign head_taken = q_taken[rd_ptr];

  // Read-port arbitration: frontend first unless the updater has starved long enough.
  assign upd_forced  = (state == S_RD) && (starve_cnt == STV_MAX);
  assign fe_rd_grant = reset && fe_rd_req && !upd_forced;
  assign upd_wins    = reset && (state == S_RD) && !fe_rd_grant;
  assign ram_rd_en   = fe_rd_grant || upd_wins;
  assign ram_rd_addr = fe_rd_grant ? fe_rd_addr : head_idx;

  assign busy = reset && ((count != '0) || (state != S_IDLE));

  // Counter update: saturating step on a tag hit, fresh strong state on a miss.
  always_comb begin
    cur_st = rd_q[1:0];
    hit    = rd_q[52] && (rd_q[51:2] == head_tag);
    new_st = head_taken ? 2'b11 : 2'b00;
    if (hit) begin
      if (head_taken) new_st = (cur_st == 2'b11) ? 2'b11 : cur_st + 2'b01;
      else            new_st = (cur_st == 2'b00) ? 2'b00 : cur_st - 2'b01;
    end
  end

  // Updater next state and RAM write port.
  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    ram_wr_en   = 1'b0;
    ram_wr_addr = head_idx;
    ram_wr_data = {1'b1, head_tag, new_st};
    case (state)
      S_INIT: begin
        ram_wr_en   = reset;
        ram_wr_addr = sweep_addr;
        ram_wr_data = INIT_WORD;
        if (sweep_addr == 12'hFFF) state_nxt = S_IDLE;
      end
      S_IDLE: if (count != '0) state_nxt = S_RD;
      S_RD:   if (upd_wins) state_nxt = S_WT;
      S_WT:   state_nxt = S_WR;
      S_WR: begin
        ram_wr_en = 1'b1;
        pop       = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_INIT;
    endcase
  end

  // State register; reset drops any update in flight and restarts the sweep.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_INIT;
    else        state <= state_nxt;
  end

  // Sweep address walks the whole table once after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                sweep_addr <= '0;
    else if (state == S_INIT)  sweep_addr <= sweep_addr + 12'd1;
  end

  // Queue pointers, occupancy and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rr_ptr <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
        rr_ptr <= ~rr_ptr;
      end
      if (pop) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Queue payload: table index, tag and resolved direction.
  always_ff @(posedge clk) begin
    if (push) begin
      q_idx[wr_ptr]   <= push_sel ? bu1_pc[13:2]  : bu0_pc[13:2];
      q_tag[wr_ptr]   <= push_sel ? bu1_pc[63:14] : bu0_pc[63:14];
      q_taken[wr_ptr] <= push_sel ? bu1_taken     : bu0_taken;
    end
  end

  // Starvation counter counts RD cycles lost to the frontend.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) starve_cnt <= '0;
    else if (state == S_RD) begin
      if (upd_wins)                  starve_cnt <= '0;
      else if (starve_cnt != STV_MAX) starve_cnt <= starve_cnt + STV_W'(1);
    end
  end

  // RAM read data is valid in WT; hold it for the WR decision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              rd_q <= '0;
    else if (state == S_WT)  rd_q <= ram_rd_data;
  end

endmodule

// File: tb/tb_bht_update_ctrl.sv
// tb/tb_bht_update_ctrl.sv - directed self-checking bench for bht_update_ctrl
module tb_bht_update_ctrl;

  localparam logic [52:0] INIT_WORD = {1'b0, 50'd0, 2'b01};

  logic        clk = 1'b0;
  logic        reset;
  logic        bu0_valid, bu0_taken, bu0_ready;
  logic [63:0] bu0_pc;
  logic        bu1_valid, bu1_taken, bu1_ready;
  logic [63:0] bu1_pc;
  logic        fe_rd_req, fe_rd_grant;
  logic [11:0] fe_rd_addr;
  logic        ram_rd_en, ram_wr_en;
  logic [11:0] ram_rd_addr, ram_wr_addr;
  logic [52:0] ram_rd_data = '0;
  logic [52:0] ram_wr_data;
  logic        init_done, busy;

  int checks = 0;
  int passed = 0;
  int cyc_cnt = 0;
  int init_exp = 0;
  int init_wr_cnt = 0;
  int init_errs = 0;

  logic [52:0] mem [4096];
  logic [11:0] wr_addr_q [$];
  logic [52:0] wr_data_q [$];
  int          wr_cyc_q  [$];

  bht_update_ctrl dut (
    .clk(clk), .reset(reset),
    .bu0_valid(bu0_valid), .bu0_pc(bu0_pc), .bu0_taken(bu0_taken), .bu0_ready(bu0_ready),
    .bu1_valid(bu1_valid), .bu1_pc(bu1_pc), .bu1_taken(bu1_taken), .bu1_ready(bu1_ready),
    .fe_rd_req(fe_rd_req), .fe_rd_addr(fe_rd_addr), .fe_rd_grant(fe_rd_grant),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .init_done(init_done), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Table RAM: one-cycle read latency, writes visible to any later read.
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
  end

  // Write monitor: checks the sweep sequence and logs update writes.
  always begin
    @(negedge clk);
    #3;
    if (!reset) begin
      init_exp    = 0;
      init_wr_cnt = 0;
      init_errs   = 0;
    end else if (ram_wr_en) begin
      if (!init_done) begin
        if (ram_wr_addr !== 12'(init_exp) || ram_wr_data !== INIT_WORD) init_errs++;
        init_exp++;
        init_wr_cnt++;
      end else begin
        wr_addr_q.push_back(ram_wr_addr);
        wr_data_q.push_back(ram_wr_data);
        wr_cyc_q.push_back(cyc_cnt + 1);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] mk_pc(input logic [49:0] tag, input logic [11:0] idx);
    return {tag, idx, 2'b11};
  endfunction

  task automatic idle_inputs();
    bu0_valid = 0; bu0_pc = '0; bu0_taken = 0;
    bu1_valid = 0; bu1_pc = '0; bu1_taken = 0;
    fe_rd_req = 0; fe_rd_addr = '0;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
  endtask

  task automatic wait_init(output int cyc);
    cyc = 0;
    while (!init_done && cyc < 5000) begin
      @(negedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic wait_writes(input int n);
    int t = 0;
    while (wr_addr_q.size() < n && t < 200) begin
      @(negedge clk);
      #4;
      t++;
    end
    check("wr_count", wr_addr_q.size(), n);
  endtask

  task automatic expect_wr(input int i, input logic [11:0] a, input logic [52:0] d);
    if (i < wr_addr_q.size()) begin
      check("wr_addr", wr_addr_q[i], a);
      check("wr_data", wr_data_q[i], d);
    end else begin
      check("wr_missing", wr_addr_q.size(), i + 1);
    end
  endtask

  task automatic push_one(input int port, input logic [63:0] pc, input logic tkn);
    int n = 0;
    @(negedge clk);
    if (port == 0) begin bu0_valid = 1; bu0_pc = pc; bu0_taken = tkn; end
    else           begin bu1_valid = 1; bu1_pc = pc; bu1_taken = tkn; end
    #1;
    while (!(port == 0 ? bu0_ready : bu1_ready) && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("push_ready", (port == 0) ? bu0_ready : bu1_ready, 1);
    @(negedge clk);
    bu0_valid = 0;
    bu1_valid = 0;
  endtask

  task automatic starve_run(input string tag);
    int n = 0;
    while (fe_rd_grant && n < 50) begin
      n++;
      @(negedge clk);
      #1;
    end
    check({tag, "_grant_cycles"}, n, 9);
    check({tag, "_rd_en"}, ram_rd_en, 1);
    check({tag, "_rd_addr"}, ram_rd_addr, 12'h300);
    @(negedge clk);
    #1;
    check({tag, "_grant_back"}, fe_rd_grant, 1);
    check({tag, "_fe_addr"}, ram_rd_addr, 12'h123);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int k0, k1, mcnt, nports;
    bit saw_full;
    int ports_q [$];
    logic [11:0] exp_a_q [$];
    logic [52:0] exp_d_q [$];
    int push_edge;

    // Reset state, with inputs that would otherwise request service.
    idle_inputs();
    reset = 0;
    bu0_valid = 1; bu1_valid = 1; fe_rd_req = 1; fe_rd_addr = 12'h055;
    repeat (2) @(negedge clk);
    #1;
    check("rst_init_done", init_done, 0);
    check("rst_bu0_ready", bu0_ready, 0);
    check("rst_bu1_ready", bu1_ready, 0);
    check("rst_fe_grant", fe_rd_grant, 0);
    check("rst_rd_en", ram_rd_en, 0);
    check("rst_wr_en", ram_wr_en, 0);
    check("rst_busy", busy, 0);
    idle_inputs();

    // Sweep after release.
    @(negedge clk);
    reset = 1;
    #1;
    check("sweep_busy", busy, 1);
    wait_init(cyc);
    check("sweep_cycles", cyc, 4096);
    check("sweep_writes", init_wr_cnt, 4096);
    check("sweep_errs", init_errs, 0);
    check("post_init_done", init_done, 1);
    check("post_bu0_ready", bu0_ready, 1);
    check("post_bu1_ready", bu1_ready, 1);
    check("post_busy", busy, 0);
    check("post_wr_en", ram_wr_en, 0);

    // Both ports valid every cycle: alternation, full stall, nothing lost.
    clear_log();
    k0 = 0; k1 = 0; mcnt = 0; saw_full = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      bu0_valid = 1; bu0_pc = mk_pc(50'(k0 + 1), 12'(256 + k0)); bu0_taken = (k0 % 2 == 1);
      bu1_valid = 1; bu1_pc = mk_pc(50'(85 + k1), 12'(512 + k1)); bu1_taken = 1;
      #1;
      check("rr_ready_vs_count", bu0_ready | bu1_ready, mcnt != 4);
      check("rr_single_grant", bu0_ready & bu1_ready, 0);
      if (!(bu0_ready | bu1_ready)) saw_full = 1;
      if (bu0_ready) begin
        ports_q.push_back(0);
        exp_a_q.push_back(12'(256 + k0));
        exp_d_q.push_back({1'b1, 50'(k0 + 1), (k0 % 2 == 1) ? 2'b11 : 2'b00});
        k0++;
      end else if (bu1_ready) begin
        ports_q.push_back(1);
        exp_a_q.push_back(12'(512 + k1));
        exp_d_q.push_back({1'b1, 50'(85 + k1), 2'b11});
        k1++;
      end
      mcnt = mcnt + ((bu0_ready | bu1_ready) ? 1 : 0) - (ram_wr_en ? 1 : 0);
    end
    @(negedge clk);
    bu0_valid = 0; bu1_valid = 0;
    check("rr_full_seen", saw_full, 1);
    nports = ports_q.size();
    for (int i = 0; i < nports; i++) check("rr_port_order", ports_q[i], i % 2);
    wait_writes(exp_a_q.size());
    for (int i = 0; i < exp_a_q.size(); i++) expect_wr(i, exp_a_q[i], exp_d_q[i]);

    // pc 0x1000: three taken, one not taken, back to back.
    clear_log();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bu0_valid = 1; bu0_pc = 64'h1000; bu0_taken = (i < 3);
      #1;
      check("sat_push_ready", bu0_ready, 1);
      if (i == 0) push_edge = cyc_cnt + 1;
    end
    @(negedge clk);
    bu0_valid = 0;
    #1;
    check("sat_busy", busy, 1);
    wait_writes(4);
    expect_wr(0, 12'h400, {1'b1, 50'd0, 2'b11});
    expect_wr(1, 12'h400, {1'b1, 50'd0, 2'b11});
    expect_wr(2, 12'h400, {1'b1, 50'd0, 2'b11});
    expect_wr(3, 12'h400, {1'b1, 50'd0, 2'b10});
    if (wr_cyc_q.size() > 0) check("latency", wr_cyc_q[0] - push_edge, 4);
    repeat (2) @(negedge clk);
    #1;
    check("drained_busy", busy, 0);

    // Same index, different tag: miss replaces, then saturates low, then steps up.
    clear_log();
    push_one(0, 64'h1000 | (64'd5 << 14), 1'b0);
    push_one(0, 64'h1000 | (64'd5 << 14), 1'b0);
    push_one(1, 64'h1000 | (64'd5 << 14), 1'b1);
    wait_writes(3);
    expect_wr(0, 12'h400, {1'b1, 50'd5, 2'b00});
    expect_wr(1, 12'h400, {1'b1, 50'd5, 2'b00});
    expect_wr(2, 12'h400, {1'b1, 50'd5, 2'b01});

    // Frontend holds the read port: updater forced through after 8 lost cycles.
    clear_log();
    @(negedge clk);
    fe_rd_req = 1; fe_rd_addr = 12'h123;
    bu1_valid = 1; bu1_pc = mk_pc(50'h3A, 12'h300); bu1_taken = 0;
    #1;
    check("stv_push_ready", bu1_ready, 1);
    @(negedge clk);
    bu1_valid = 0;
    #1;
    starve_run("stv1");
    repeat (3) @(negedge clk);
    bu1_valid = 1; bu1_taken = 1;
    #1;
    check("stv_push2_ready", bu1_ready, 1);
    @(negedge clk);
    bu1_valid = 0;
    #1;
    starve_run("stv2");
    fe_rd_req = 0;
    wait_writes(2);
    expect_wr(0, 12'h300, {1'b1, 50'h3A, 2'b00});
    expect_wr(1, 12'h300, {1'b1, 50'h3A, 2'b01});

    // Reset during WT: update is lost, sweep restarts from 0.
    clear_log();
    @(negedge clk);
    bu0_valid = 1; bu0_pc = mk_pc(50'h77, 12'h0AB); bu0_taken = 1;
    #1;
    check("wt_push_ready", bu0_ready, 1);
    @(negedge clk);
    bu0_valid = 0;
    @(negedge clk);
    #1;
    check("wt_rd_en", ram_rd_en, 1);
    check("wt_rd_addr", ram_rd_addr, 12'h0AB);
    @(negedge clk);
    reset = 0;
    #1;
    check("wt_rst_wr_en", ram_wr_en, 0);
    check("wt_rst_init_done", init_done, 0);
    check("wt_rst_ready", {bu0_ready, bu1_ready}, 0);
    check("wt_rst_busy", busy, 0);
    @(negedge clk);
    reset = 1;
    #1;
    wait_init(cyc);
    check("resweep_cycles", cyc, 4096);
    check("resweep_writes", init_wr_cnt, 4096);
    check("resweep_errs", init_errs, 0);
    repeat (10) @(negedge clk);
    #4;
    check("wt_no_update_write", wr_addr_q.size(), 0);
    check("wt_entry_cleared", mem[12'h0AB], INIT_WORD);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
